// File: rtl/jts16_tile_fetch_arb.sv
// Round-robin arbiter sharing one tile-ROM SDRAM slot between the char and two scroll layers.
// Keeps a one-word cache per client and abandons SDRAM accesses that stall past TIMEOUT.
module jts16_tile_fetch_arb #(
    parameter int            AW          = 18,
    parameter logic [AW-1:0] CHAR_OFFSET = 18'h00000,
    parameter logic [AW-1:0] SCR1_OFFSET = 18'h02000,
    parameter logic [AW-1:0] SCR2_OFFSET = 18'h02000,
    parameter int            TIMEOUT     = 63
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          char_cs,
    input  logic [12:0]   char_addr,
    output logic          char_ok,
    output logic [31:0]   char_data,
    input  logic          scr1_cs,
    input  logic [16:0]   scr1_addr,
    output logic          scr1_ok,
    output logic [31:0]   scr1_data,
    input  logic          scr2_cs,
    input  logic [16:0]   scr2_addr,
    output logic          scr2_ok,
    output logic [31:0]   scr2_data,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic          rom_ok,
    input  logic [31:0]   rom_data,
    output logic          timeout
);

    typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

    state_t             state_q, state_d;
    logic [2:0]         cs_w;
    logic [2:0][16:0]   addr_w;
    logic [2:0][16:0]   la_q;
    logic [2:0]         v_q;
    logic [2:0][31:0]   data_q;
    logic [2:0]         hit, pend;
    logic [1:0]         ptr_q, ptr_d, g_q, g_d, next_ptr;
    logic [16:0]        ga_q, ga_d;
    logic               rom_cs_q, rom_cs_d;
    logic [AW-1:0]      rom_addr_q, rom_addr_d;
    logic [5:0]         timer_q, timer_d;
    logic               timeout_q, timeout_d;
    logic               wr_en;
    logic               gnt_vld;
    logic [1:0]         gnt_idx;

    assign cs_w      = {scr2_cs, scr1_cs, char_cs};
    assign addr_w[0] = {4'd0, char_addr};
    assign addr_w[1] = scr1_addr;
    assign addr_w[2] = scr2_addr;

    function automatic logic [1:0] wrap3(input logic [1:0] p, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, k};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    function automatic logic [AW-1:0] client_offset(input logic [1:0] idx);
        case (idx)
            2'd0:    return CHAR_OFFSET;
            2'd1:    return SCR1_OFFSET;
            default: return SCR2_OFFSET;
        endcase
    endfunction

    // Cache hit is combinational on the live address so ok drops the cycle the address moves
    always_comb begin
        hit = '0;
        for (int i = 0; i < 3; i++) hit[i] = v_q[i] && (addr_w[i] == la_q[i]);
    end

    assign pend = cs_w & ~hit;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr_q;
        for (int k = 2; k >= 0; k--) begin
            if (pend[wrap3(ptr_q, 2'(k))]) begin
                gnt_vld = 1'b1;
                gnt_idx = wrap3(ptr_q, 2'(k));
            end
        end
    end

    assign next_ptr = (g_q == 2'd2) ? 2'd0 : g_q + 2'd1;

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        ga_d       = ga_q;
        rom_cs_d   = rom_cs_q;
        rom_addr_d = rom_addr_q;
        timer_d    = timer_q;
        ptr_d      = ptr_q;
        timeout_d  = timeout_q;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    g_d        = gnt_idx;
                    ga_d       = addr_w[gnt_idx];
                    rom_addr_d = AW'(addr_w[gnt_idx]) + client_offset(gnt_idx);
                    rom_cs_d   = 1'b1;
                    timer_d    = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (rom_ok) begin
                    // A word fetched for an address the client has since left is dropped
                    wr_en    = cs_w[g_q] && (addr_w[g_q] == ga_q);
                    rom_cs_d = 1'b0;
                    ptr_d    = next_ptr;
                    state_d  = GAP;
                end else if (timer_q == 6'(TIMEOUT - 1)) begin
                    rom_cs_d  = 1'b0;
                    timeout_d = 1'b1;
                    ptr_d     = next_ptr;
                    state_d   = GAP;
                end else begin
                    timer_d = timer_q + 6'd1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            g_q        <= '0;
            ga_q       <= '0;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
            timer_q    <= '0;
            ptr_q      <= '0;
            timeout_q  <= 1'b0;
            la_q       <= '0;
            v_q        <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            ga_q       <= ga_d;
            rom_cs_q   <= rom_cs_d;
            rom_addr_q <= rom_addr_d;
            timer_q    <= timer_d;
            ptr_q      <= ptr_d;
            timeout_q  <= timeout_d;
            if (wr_en) begin
                data_q[g_q] <= rom_data;
                la_q[g_q]   <= ga_q;
                v_q[g_q]    <= 1'b1;
            end
        end
    end

    assign char_ok   = cs_w[0] && hit[0];
    assign scr1_ok   = cs_w[1] && hit[1];
    assign scr2_ok   = cs_w[2] && hit[2];
    assign char_data = data_q[0];
    assign scr1_data = data_q[1];
    assign scr2_data = data_q[2];
    assign rom_cs    = rom_cs_q;
    assign rom_addr  = rom_addr_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_jts16_tile_fetch_arb.sv
// Bench for jts16_tile_fetch_arb: SDRAM responder plus an event-level model of the
// per-client caches and round-robin grants, directed scenarios and a randomized run.
module tb_jts16_tile_fetch_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        char_cs, scr1_cs, scr2_cs;
    logic [12:0] char_addr;
    logic [16:0] scr1_addr, scr2_addr;
    logic        char_ok, scr1_ok, scr2_ok;
    logic [31:0] char_data, scr1_data, scr2_data;
    logic        rom_cs;
    logic [17:0] rom_addr;
    logic        rom_ok = 1'b0;
    logic [31:0] rom_data = 32'h0;
    logic        timeout;

    int checks = 0, failures = 0;

    // knobs owned by the test tasks
    int          lat_cfg = 4;
    bit          rand_lat = 0, mute = 0, fixed_en = 0;
    logic [31:0] fixed_word = 32'h0;
    int          force_req = 0;

    // state owned by the monitor
    int          force_seen = 0, lat_cur = 4, cnt = 0, pick = 0, idx = 0;
    logic        prev_cs = 1'b0;
    bit          m_v[3];
    logic [16:0] m_la[3];
    logic [31:0] m_data[3];
    int          m_ptr = 0, m_g = 0;
    logic [16:0] m_ga = '0;
    logic [17:0] exp_a[$], act_a[$];

    always #5 clk = ~clk;

    jts16_tile_fetch_arb dut (
        .clk(clk), .rst(rst),
        .char_cs(char_cs), .char_addr(char_addr), .char_ok(char_ok), .char_data(char_data),
        .scr1_cs(scr1_cs), .scr1_addr(scr1_addr), .scr1_ok(scr1_ok), .scr1_data(scr1_data),
        .scr2_cs(scr2_cs), .scr2_addr(scr2_addr), .scr2_ok(scr2_ok), .scr2_data(scr2_data),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_ok(rom_ok), .rom_data(rom_data),
        .timeout(timeout)
    );

    function automatic logic [31:0] word(input logic [17:0] a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5AA5A5;
    endfunction

    function automatic bit cur_cs(input int i);
        case (i)
            0:       return char_cs;
            1:       return scr1_cs;
            default: return scr2_cs;
        endcase
    endfunction

    function automatic logic [16:0] cur_addr(input int i);
        case (i)
            0:       return {4'd0, char_addr};
            1:       return scr1_addr;
            default: return scr2_addr;
        endcase
    endfunction

    function automatic logic [17:0] rom_of(input int i, input logic [16:0] a);
        return 18'(a) + ((i == 0) ? 18'h00000 : 18'h02000);
    endfunction

    // Inputs only change at negedge+1, so at a negedge they equal what the last posedge saw
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_v[i] = 0; m_la[i] = '0; m_data[i] = '0;
            end
            m_ptr = 0; prev_cs = 1'b0; cnt = 0; rom_ok = 1'b0;
        end else begin
            if (prev_cs && rom_ok) begin
                if (cur_cs(m_g) && cur_addr(m_g) == m_ga) begin
                    m_v[m_g] = 1; m_la[m_g] = m_ga; m_data[m_g] = rom_data;
                end
                m_ptr = (m_g + 1) % 3;
            end else if (prev_cs && !rom_cs) begin
                m_ptr = (m_g + 1) % 3;
            end
            if (rom_cs && !prev_cs) begin
                pick = -1;
                for (int k = 0; k < 3; k++) begin
                    idx = (m_ptr + k) % 3;
                    if (pick < 0 && cur_cs(idx) && !(m_v[idx] && cur_addr(idx) == m_la[idx])) pick = idx;
                end
                if (pick >= 0) begin
                    m_g = pick; m_ga = cur_addr(pick);
                    exp_a.push_back(rom_of(pick, m_ga));
                end else begin
                    exp_a.push_back(18'bx);
                end
                act_a.push_back(rom_addr);
                lat_cur = rand_lat ? int'($urandom_range(1, 6)) : lat_cfg;
            end
            rom_ok = 1'b0;
            if (!rom_cs) cnt = 0;
            else if (!mute) begin
                cnt++;
                if (cnt == lat_cur) begin
                    rom_ok = 1'b1;
                    rom_data = fixed_en ? fixed_word : word(rom_addr);
                end
            end
            if (force_req != force_seen) begin
                rom_ok = 1'b1; rom_data = 32'h12345678; force_seen = force_req;
            end
            prev_cs = rom_cs;
        end
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic wait_sig(input int which, input logic val, input int max, output bit found);
        logic s;
        found = 0;
        for (int n = 0; n < max; n++) begin
            case (which)
                0:       s = rom_cs;
                1:       s = char_ok;
                2:       s = scr1_ok;
                default: s = scr2_ok;
            endcase
            if (s === val) begin found = 1; return; end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; char_cs = 0; scr1_cs = 0; scr2_cs = 0;
        char_addr = '0; scr1_addr = '0; scr2_addr = '0;
        #2 rst = 1'b1;
        step(); step();
        checks++; if (rom_cs !== 1'b0) begin failures++; $display("FAIL reset_rom_cs got=%b exp=0", rom_cs); end
        checks++; if (rom_addr !== 18'h0) begin failures++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
        checks++; if ({char_ok, scr1_ok, scr2_ok} !== 3'b000) begin failures++; $display("FAIL reset_ok got=%b exp=000", {char_ok, scr1_ok, scr2_ok}); end
        checks++; if ({char_data, scr1_data, scr2_data} !== 96'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {char_data, scr1_data, scr2_data}); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        rst = 1'b0;
        step(); step();
        checks++; if (rom_cs !== 1'b0) begin failures++; $display("FAIL idle_rom_cs got=%b exp=0", rom_cs); end
    endtask

    task automatic test_all_pending();
        logic [17:0] ga[4];
        int tr[4], tok[3], nr;
        logic lcs;
        nr = 0; lcs = 1'b0; lat_cfg = 3;
        for (int i = 0; i < 3; i++) tok[i] = -1;
        char_addr = 13'h0AAA; scr1_addr = 17'h00010; scr2_addr = 17'h1FFF0;
        char_cs = 1; scr1_cs = 1; scr2_cs = 1;
        for (int n = 0; n < 60; n++) begin
            step();
            if (rom_cs && !lcs && nr < 4) begin ga[nr] = rom_addr; tr[nr] = n; nr++; end
            lcs = rom_cs;
            if (char_ok && tok[0] < 0) tok[0] = n;
            if (scr1_ok && tok[1] < 0) tok[1] = n;
            if (scr2_ok && tok[2] < 0) tok[2] = n;
        end
        checks++; if (nr != 3) begin failures++; $display("FAIL rr_grant_count got=%0d exp=3", nr); end
        else begin
            checks++; if (ga[0] !== 18'h00AAA) begin failures++; $display("FAIL rr_char_addr got=%h exp=00aaa", ga[0]); end
            checks++; if (ga[1] !== 18'h02010) begin failures++; $display("FAIL rr_scr1_addr got=%h exp=02010", ga[1]); end
            checks++; if (ga[2] !== 18'h21FF0) begin failures++; $display("FAIL rr_scr2_addr got=%h exp=21ff0", ga[2]); end
            checks++; if (!(tok[0] > tr[0] && tok[0] < tr[1])) begin failures++; $display("FAIL rr_char_ok_time got=%0d exp=(%0d,%0d)", tok[0], tr[0], tr[1]); end
            checks++; if (!(tok[1] > tr[1] && tok[1] < tr[2])) begin failures++; $display("FAIL rr_scr1_ok_time got=%0d exp=(%0d,%0d)", tok[1], tr[1], tr[2]); end
            checks++; if (!(tok[2] > tr[2])) begin failures++; $display("FAIL rr_scr2_ok_time got=%0d exp=>%0d", tok[2], tr[2]); end
        end
        checks++; if (char_data !== word(18'h00AAA)) begin failures++; $display("FAIL rr_char_data got=%h exp=%h", char_data, word(18'h00AAA)); end
        checks++; if (scr1_data !== word(18'h02010)) begin failures++; $display("FAIL rr_scr1_data got=%h exp=%h", scr1_data, word(18'h02010)); end
        checks++; if (scr2_data !== word(18'h21FF0)) begin failures++; $display("FAIL rr_scr2_data got=%h exp=%h", scr2_data, word(18'h21FF0)); end
    endtask

    task automatic test_char_only();
        bit f;
        int hi;
        scr1_cs = 0; scr2_cs = 0;
        fixed_en = 1; fixed_word = 32'hDEADBEEF; lat_cfg = 4;
        char_addr = 13'h0155;
        wait_sig(0, 1'b1, 20, f);
        checks++; if (!f) begin failures++; $display("FAIL char_grant got=none exp=rom_cs"); end
        checks++; if (rom_addr !== 18'h00155) begin failures++; $display("FAIL char_rom_addr got=%h exp=00155", rom_addr); end
        step(); step(); step();
        checks++; if (rom_ok !== 1'b1 || char_ok !== 1'b0) begin failures++; $display("FAIL char_ok_before got=ok%b/char_ok%b exp=1/0", rom_ok, char_ok); end
        step();
        checks++; if (char_ok !== 1'b1) begin failures++; $display("FAIL char_ok_rise got=%b exp=1", char_ok); end
        checks++; if (char_data !== 32'hDEADBEEF) begin failures++; $display("FAIL char_data got=%h exp=deadbeef", char_data); end
        checks++; if (rom_cs !== 1'b0) begin failures++; $display("FAIL char_rom_cs_drop got=%b exp=0", rom_cs); end
        hi = 0;
        for (int n = 0; n < 20; n++) begin step(); if (rom_cs) hi++; end
        checks++; if (hi != 0 || char_ok !== 1'b1) begin failures++; $display("FAIL char_no_refetch got=%0d/ok%b exp=0/1", hi, char_ok); end
        fixed_en = 0;
    endtask

    task automatic test_addr_change();
        bit f;
        lat_cfg = 6;
        char_addr = 13'h0001;
        wait_sig(0, 1'b1, 20, f);
        checks++; if (!f || rom_addr !== 18'h00001) begin failures++; $display("FAIL chg_first_addr got=%h exp=00001", rom_addr); end
        step(); step();
        char_addr = 13'h0002;
        wait_sig(0, 1'b0, 20, f);
        checks++; if (!f) begin failures++; $display("FAIL chg_first_done got=stuck exp=rom_cs_low"); end
        step();
        checks++; if (char_ok !== 1'b0 || char_data !== 32'hDEADBEEF) begin failures++; $display("FAIL chg_discard got=%b/%h exp=0/deadbeef", char_ok, char_data); end
        wait_sig(0, 1'b1, 10, f);
        checks++; if (!f || rom_addr !== 18'h00002) begin failures++; $display("FAIL chg_refetch_addr got=%h exp=00002", rom_addr); end
        checks++; if (char_ok !== 1'b0) begin failures++; $display("FAIL chg_ok_early got=%b exp=0", char_ok); end
        wait_sig(1, 1'b1, 20, f);
        checks++; if (!f || char_data !== word(18'h00002)) begin failures++; $display("FAIL chg_final got=%b/%h exp=1/%h", f, char_data, word(18'h00002)); end
    endtask

    task automatic test_timeout();
        bit f;
        int n;
        mute = 1; lat_cfg = 3;
        char_addr = 13'h0100; scr1_addr = 17'h00020; scr1_cs = 1;
        wait_sig(0, 1'b1, 20, f);
        checks++; if (!f || rom_addr !== 18'h02020) begin failures++; $display("FAIL to_first_grant got=%h exp=02020", rom_addr); end
        n = 0;
        while (rom_cs && n < 100) begin n++; step(); end
        checks++; if (n != 63) begin failures++; $display("FAIL to_wait_cycles got=%0d exp=63", n); end
        checks++; if (timeout !== 1'b1 || scr1_ok !== 1'b0) begin failures++; $display("FAIL to_flag got=%b/ok%b exp=1/0", timeout, scr1_ok); end
        mute = 0;
        wait_sig(0, 1'b1, 10, f);
        checks++; if (!f || rom_addr !== 18'h00100) begin failures++; $display("FAIL to_next_grant got=%h exp=00100", rom_addr); end
        wait_sig(1, 1'b1, 20, f);
        checks++; if (!f) begin failures++; $display("FAIL to_char_ok got=0 exp=1"); end
        wait_sig(0, 1'b1, 10, f);
        checks++; if (!f || rom_addr !== 18'h02020) begin failures++; $display("FAIL to_retry_addr got=%h exp=02020", rom_addr); end
        wait_sig(2, 1'b1, 20, f);
        checks++; if (!f || scr1_data !== word(18'h02020)) begin failures++; $display("FAIL to_retry_ok got=%b/%h exp=1/%h", f, scr1_data, word(18'h02020)); end
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", timeout); end
    endtask

    task automatic test_reset_mid();
        bit f;
        lat_cfg = 10;
        char_addr = 13'h0200;
        wait_sig(0, 1'b1, 20, f);
        checks++; if (!f || rom_addr !== 18'h00200) begin failures++; $display("FAIL rm_grant got=%h exp=00200", rom_addr); end
        step(); step();
        rst = 1'b1; char_cs = 0; scr1_cs = 0; scr2_cs = 0;
        #1;
        checks++; if (rom_cs !== 1'b0) begin failures++; $display("FAIL rm_rom_cs got=%b exp=0", rom_cs); end
        checks++; if ({char_ok, scr1_ok, scr2_ok, timeout} !== 4'b0) begin failures++; $display("FAIL rm_outs got=%b exp=0000", {char_ok, scr1_ok, scr2_ok, timeout}); end
        checks++; if (char_data !== 32'h0) begin failures++; $display("FAIL rm_data got=%h exp=0", char_data); end
        step();
        rst = 1'b0;
        step();
        force_req++;
        step(); step(); step();
        checks++; if (rom_cs !== 1'b0 || char_data !== 32'h0 || scr1_data !== 32'h0) begin failures++; $display("FAIL rm_late_ok got=%b/%h/%h exp=0/0/0", rom_cs, char_data, scr1_data); end
        lat_cfg = 2;
        char_addr = 13'h0300; scr1_addr = 17'h00030; scr2_addr = 17'h00040;
        char_cs = 1; scr1_cs = 1; scr2_cs = 1;
        wait_sig(0, 1'b1, 10, f);
        checks++; if (!f || rom_addr !== 18'h00300) begin failures++; $display("FAIL rm_first_grant got=%h exp=00300", rom_addr); end
        wait_sig(3, 1'b1, 60, f);
        checks++; if (!f || scr2_data !== word(18'h02040)) begin failures++; $display("FAIL rm_scr2 got=%b/%h exp=1/%h", f, scr2_data, word(18'h02040)); end
    endtask

    task automatic test_cs_toggle();
        int hi;
        scr1_cs = 0; scr2_cs = 0;
        step();
        checks++; if (char_ok !== 1'b1) begin failures++; $display("FAIL tog_ok_start got=%b exp=1", char_ok); end
        char_cs = 0; #1;
        checks++; if (char_ok !== 1'b0) begin failures++; $display("FAIL tog_ok_drop got=%b exp=0", char_ok); end
        step(); step();
        checks++; if (char_ok !== 1'b0 || rom_cs !== 1'b0) begin failures++; $display("FAIL tog_idle got=%b/%b exp=0/0", char_ok, rom_cs); end
        char_cs = 1; #1;
        checks++; if (char_ok !== 1'b1 || char_data !== word(18'h00300)) begin failures++; $display("FAIL tog_ok_back got=%b/%h exp=1/%h", char_ok, char_data, word(18'h00300)); end
        hi = 0;
        for (int n = 0; n < 10; n++) begin step(); if (rom_cs) hi++; end
        checks++; if (hi != 0) begin failures++; $display("FAIL tog_no_fetch got=%0d exp=0", hi); end
    endtask

    task automatic test_random();
        int rd;
        logic e, okv;
        logic [31:0] dv;
        rd = act_a.size();
        rand_lat = 1;
        for (int n = 0; n < 500; n++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                e   = cur_cs(i) && m_v[i] && (cur_addr(i) == m_la[i]);
                okv = (i == 0) ? char_ok : (i == 1) ? scr1_ok : scr2_ok;
                dv  = (i == 0) ? char_data : (i == 1) ? scr1_data : scr2_data;
                checks++; if (okv !== e) begin failures++; $display("FAIL rnd_ok%0d cyc=%0d got=%b exp=%b", i, n, okv, e); end
                if (e) begin
                    checks++; if (dv !== m_data[i]) begin failures++; $display("FAIL rnd_data%0d cyc=%0d got=%h exp=%h", i, n, dv, m_data[i]); end
                end
            end
            while (rd < act_a.size()) begin
                checks++; if (act_a[rd] !== exp_a[rd]) begin failures++; $display("FAIL rnd_grant%0d got=%h exp=%h", rd, act_a[rd], exp_a[rd]); end
                rd++;
            end
            if ($urandom_range(0, 5) == 0) char_cs = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 5) == 0) char_addr = 13'h0040 + 13'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) scr1_cs = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 5) == 0) scr1_addr = 17'h1FFFC + 17'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) scr2_cs = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 5) == 0) scr2_addr = 17'h00100 + 17'($urandom_range(0, 3));
        end
        rand_lat = 0;
    endtask

    initial begin
        test_reset();
        test_all_pending();
        test_char_only();
        test_addr_change();
        test_timeout();
        test_reset_mid();
        test_cs_toggle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

endmodule
